ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
Owns the single write/address port of the program RAM and grants it to either the switch-based program loader or the CPU core. Sequences the board flow: program entry from switches, run, halt, re-program. Debounces the raw load button, converts load presses into single-cycle RAM writes, and gates the core's run enable. Sits between cpu_core, the board switches/buttons, and the RAM.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a load_btn level change (min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  run request level from board; rising edge acted on
load_btn  in  1  raw asynchronous load push-button
sw_addr  in  ADDR_W  switch address for program entry
sw_data  in  DATA_W  switch data for program entry
cpu_addr  in  ADDR_W  core RAM address
cpu_wdata  in  DATA_W  core RAM write data
cpu_we  in  1  core RAM write request
cpu_halt  in  1  core has executed HLT (level)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
cpu_run  out  1  core execute enable
cpu_clr  out  1  one-cycle core clear pulse (PC/registers) on run entry
mode  out  2  00 LOAD, 01 WRITE, 10 RUN, 11 HALTED
write_count  out  ADDR_W+1  loader writes since reset, saturating at 2^ADDR_W

Behaviour:
- Reset (sync, clk edge with reset=1): state LOAD; ram_addr=0, ram_wdata=0, ram_we=0, cpu_run=0, cpu_clr=0, write_count=0; sync/debounce regs and start edge reg cleared (debounced level=0). Reset overrides all other inputs; an in-flight WRITE is dropped (ram_we=0 the cycle after reset).
- load_btn: 2-flop synchronizer; stable counter resets on any change of synced value; debounced level takes synced value once it has been stable DEBOUNCE_CYCLES cycles. load_pulse = one-cycle pulse on debounced 0->1. Holding the button yields exactly one pulse.
- start_rise = start & ~start_q (start_q registered).
- LOAD: ram_we=0, cpu_run=0. start_rise -> RUN (priority over load_pulse; simultaneous load_pulse discarded). Else load_pulse -> WRITE, latching sw_addr/sw_data into ram_addr/ram_wdata.
- WRITE: exactly one cycle; ram_we=1 with latched addr/data; write_count += 1 unless already 2^ADDR_W; unconditionally -> LOAD. Switch changes during WRITE do not affect the write. start_rise during WRITE ignored.
- Entry to RUN: cpu_clr=1 for the first RUN cycle only; cpu_run=1 from the first RUN cycle.
- RUN: ram_addr/ram_wdata/ram_we driven combinationally from cpu_addr/cpu_wdata/cpu_we (zero latency). load_pulse and start_rise ignored. cpu_halt=1 -> HALTED next cycle; a cpu_we coincident with cpu_halt is still passed through that cycle.
- HALTED: cpu_run=0, ram_we=0, ram_addr/ram_wdata hold last registered values. start_rise -> RUN (with cpu_clr pulse); else load_pulse -> LOAD (pulse consumed, no write). Both together: RUN wins.
- Outside RUN, ram_addr/ram_wdata are registered outputs; ram_we never asserts in LOAD or HALTED.
- write_count is never cleared except by reset.

Test Plan:
- Reset then load_btn held high 20 cycles with sw_addr=3, sw_data=0x2A -> single ram_we pulse after sync+DEBOUNCE_CYCLES, ram_addr=3, ram_wdata=0x2A, write_count=1, mode returns 00.
- load_btn bouncing (toggle every 2 cycles for 10 cycles, then steady high) -> exactly one write; a glitch shorter than DEBOUNCE_CYCLES -> no write.
- 17 debounced presses with ADDR_W=4 -> write_count saturates at 16; 17th write still occurs on RAM.
- start rising in LOAD -> cpu_clr high exactly 1 cycle, cpu_run=1; cpu_addr=5, cpu_wdata=0x11, cpu_we=1 -> same-cycle ram_addr=5, ram_wdata=0x11, ram_we=1; load press during RUN -> no write, mode stays 10.
- cpu_halt in RUN -> mode=11, cpu_run=0; start toggled 0->1 -> back to RUN with cpu_clr pulse; alternatively load press -> mode=00 with no write.
- start_rise and load_pulse same cycle in LOAD -> RUN, no write; reset asserted during WRITE -> ram_we=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Board, core and RAM signals seen by the program-RAM port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding board/core.
interface ram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              load_btn;
    logic [ADDR_W-1:0] sw_addr;
    logic [DATA_W-1:0] sw_data;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_halt;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              cpu_run;
    logic              cpu_clr;
    logic [1:0]        mode;
    logic [ADDR_W:0]   write_count;

    modport slave (
        input  start, load_btn, sw_addr, sw_data, cpu_addr, cpu_wdata, cpu_we, cpu_halt,
        output ram_addr, ram_wdata, ram_we, cpu_run, cpu_clr, mode, write_count
    );

    modport master (
        output start, load_btn, sw_addr, sw_data, cpu_addr, cpu_wdata, cpu_we, cpu_halt,
        input  ram_addr, ram_wdata, ram_we, cpu_run, cpu_clr, mode, write_count
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Grants the program RAM write/address port to the switch loader or the CPU core, sequencing
// load -> run -> halt -> re-program. Debounces the load button into single write pulses.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 reset,
    ram_access_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W:0] WCNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    // Encoding doubles as the mode output.
    typedef enum logic [1:0] {
        StLoad   = 2'b00,
        StWrite  = 2'b01,
        StRun    = 2'b10,
        StHalted = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] stable_q;
    logic             db_q, db_prev_q;
    logic             start_q;
    logic             load_pulse, start_rise;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W:0]   wcnt_q;
    logic              clr_q;

    assign load_pulse = db_q & ~db_prev_q;
    assign start_rise = bus.start & ~start_q;

    // Synchronize and debounce the load button; register start for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            sync1_q   <= bus.load_btn;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            start_q   <= bus.start;
            // Count consecutive samples that disagree with the accepted level; any sample
            // matching it means the synced value changed back, so restart the count.
            if (sync2_q == db_q) begin
                stable_q <= '0;
            end else if (stable_q == CNT_LAST) begin
                db_q     <= sync2_q;
                stable_q <= '0;
            end else begin
                stable_q <= stable_q + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start_rise outranks load_pulse wherever both are acted on.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: begin
                if (start_rise) begin
                    state_d = StRun;
                end else if (load_pulse) begin
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StLoad;
            StRun: begin
                if (bus.cpu_halt) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (start_rise) begin
                    state_d = StRun;
                end else if (load_pulse) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Loader address/data latch, write counter and the run-entry clear flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            wcnt_q <= '0;
            clr_q  <= 1'b0;
        end else begin
            if (state_q == StLoad && state_d == StWrite) begin
                addr_q <= bus.sw_addr;
                data_q <= bus.sw_data;
            end
            if (state_q == StWrite && wcnt_q != WCNT_MAX) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            clr_q <= (state_d == StRun) && (state_q != StRun);
        end
    end

    // Output logic: core drives the RAM combinationally only while running.
    always_comb begin
        bus.ram_addr  = addr_q;
        bus.ram_wdata = data_q;
        bus.ram_we    = 1'b0;
        bus.cpu_run   = 1'b0;
        unique case (state_q)
            StWrite: bus.ram_we = 1'b1;
            StRun: begin
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
                bus.ram_we    = bus.cpu_we;
                bus.cpu_run   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cpu_clr     = clr_q;
    assign bus.mode        = state_q;
    assign bus.write_count = wcnt_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with hand-computed expectations.
module tb_ram_access_arbiter;
    logic clk;
    logic reset;

    int n_cmp;
    int n_err;
    logic [3:0] last_addr;
    logic [7:0] last_data;
    int nw;

    ram_access_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_access_arbiter #(
        .ADDR_W(4),
        .DATA_W(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick n cycles, counting cycles with ram_we high and remembering the last write.
    task automatic run_count(input int n, inout int cnt);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.ram_we === 1'b1) begin
                cnt++;
                last_addr = bus.ram_addr;
                last_data = bus.ram_wdata;
            end
        end
    endtask

    // Hold the button long enough to debounce, then release long enough to debounce low.
    task automatic press(input logic [3:0] a, input logic [7:0] d, output int writes);
        int c;
        c = 0;
        bus.sw_addr  = a;
        bus.sw_data  = d;
        bus.load_btn = 1'b1;
        run_count(9, c);
        bus.load_btn = 1'b0;
        run_count(7, c);
        writes = c;
    endtask

    task automatic do_reset();
        bus.start    = 1'b0;
        bus.load_btn = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_halt = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " mode"}, 32'(bus.mode), 32'h0);
        check_eq({tag, " ram_we"}, 32'(bus.ram_we), 32'h0);
        check_eq({tag, " ram_addr"}, 32'(bus.ram_addr), 32'h0);
        check_eq({tag, " ram_wdata"}, 32'(bus.ram_wdata), 32'h0);
        check_eq({tag, " cpu_run"}, 32'(bus.cpu_run), 32'h0);
        check_eq({tag, " cpu_clr"}, 32'(bus.cpu_clr), 32'h0);
        check_eq({tag, " write_count"}, 32'(bus.write_count), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nw = 0;
        bus.sw_addr   = '0;
        bus.sw_data   = '0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        do_reset();
        check_reset_outputs("reset");

        // Single held press: 2 sync + 4 debounce edges, pulse, then WRITE on the 7th edge.
        bus.sw_addr  = 4'd3;
        bus.sw_data  = 8'h2A;
        bus.load_btn = 1'b1;
        repeat (6) tick();
        check_eq("early_we", 32'(bus.ram_we), 32'h0);
        tick();
        check_eq("write_mode", 32'(bus.mode), 32'h1);
        check_eq("write_we", 32'(bus.ram_we), 32'h1);
        check_eq("write_addr", 32'(bus.ram_addr), 32'h3);
        check_eq("write_data", 32'(bus.ram_wdata), 32'h2A);
        bus.sw_addr = 4'd7;
        bus.sw_data = 8'hFF;
        tick();
        check_eq("after_write_mode", 32'(bus.mode), 32'h0);
        check_eq("after_write_we", 32'(bus.ram_we), 32'h0);
        check_eq("after_write_addr", 32'(bus.ram_addr), 32'h3);
        check_eq("count1", 32'(bus.write_count), 32'h1);
        nw = 0;
        run_count(12, nw);
        check_eq("held_no_repeat", 32'(nw), 32'h0);
        bus.load_btn = 1'b0;
        repeat (8) tick();

        // Bouncing button then steady high: exactly one write.
        bus.sw_addr = 4'd4;
        bus.sw_data = 8'h55;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            bus.load_btn = (i % 2 == 0);
            run_count(2, nw);
        end
        bus.load_btn = 1'b1;
        run_count(15, nw);
        check_eq("bounce_writes", 32'(nw), 32'h1);
        check_eq("bounce_addr", 32'(last_addr), 32'h4);
        check_eq("bounce_data", 32'(last_data), 32'h55);
        bus.load_btn = 1'b0;
        repeat (8) tick();
        check_eq("count2", 32'(bus.write_count), 32'h2);

        // Glitch three cycles long (one short of the debounce length): no write.
        nw = 0;
        bus.load_btn = 1'b1;
        run_count(3, nw);
        bus.load_btn = 1'b0;
        run_count(12, nw);
        check_eq("glitch_writes", 32'(nw), 32'h0);
        check_eq("glitch_count", 32'(bus.write_count), 32'h2);

        // Presses 3..16 reach the saturation value, the 17th still writes.
        for (int i = 0; i < 14; i++) begin
            press(4'(i), 8'(i + 8'h80), nw);
        end
        check_eq("count16", 32'(bus.write_count), 32'h10);
        press(4'd9, 8'h99, nw);
        check_eq("press17_writes", 32'(nw), 32'h1);
        check_eq("press17_addr", 32'(last_addr), 32'h9);
        check_eq("press17_data", 32'(last_data), 32'h99);
        check_eq("count_sat", 32'(bus.write_count), 32'h10);

        // Start in LOAD: one-cycle clear, run enable, combinational core passthrough.
        bus.start = 1'b1;
        tick();
        check_eq("run_mode", 32'(bus.mode), 32'h2);
        check_eq("run_clr1", 32'(bus.cpu_clr), 32'h1);
        check_eq("run_run", 32'(bus.cpu_run), 32'h1);
        tick();
        check_eq("run_clr2", 32'(bus.cpu_clr), 32'h0);
        bus.cpu_addr  = 4'd5;
        bus.cpu_wdata = 8'h11;
        bus.cpu_we    = 1'b1;
        #1;
        check_eq("pass_addr", 32'(bus.ram_addr), 32'h5);
        check_eq("pass_data", 32'(bus.ram_wdata), 32'h11);
        check_eq("pass_we", 32'(bus.ram_we), 32'h1);
        bus.cpu_we = 1'b0;
        press(4'd1, 8'h01, nw);
        check_eq("run_press_writes", 32'(nw), 32'h0);
        check_eq("run_press_mode", 32'(bus.mode), 32'h2);
        check_eq("run_press_count", 32'(bus.write_count), 32'h10);

        // Halt with a coincident core write, then restart via a fresh start edge.
        bus.cpu_addr  = 4'd6;
        bus.cpu_wdata = 8'h66;
        bus.cpu_we    = 1'b1;
        bus.cpu_halt  = 1'b1;
        #1;
        check_eq("halt_cycle_we", 32'(bus.ram_we), 32'h1);
        tick();
        bus.cpu_we   = 1'b0;
        bus.cpu_halt = 1'b0;
        #1;
        check_eq("halted_mode", 32'(bus.mode), 32'h3);
        check_eq("halted_run", 32'(bus.cpu_run), 32'h0);
        check_eq("halted_we", 32'(bus.ram_we), 32'h0);
        check_eq("halted_addr", 32'(bus.ram_addr), 32'h9);
        check_eq("halted_data", 32'(bus.ram_wdata), 32'h99);
        bus.start = 1'b0;
        tick();
        check_eq("halted_hold", 32'(bus.mode), 32'h3);
        bus.start = 1'b1;
        tick();
        check_eq("rerun_mode", 32'(bus.mode), 32'h2);
        check_eq("rerun_clr", 32'(bus.cpu_clr), 32'h1);

        // Halt again, then a load press returns to LOAD without writing.
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
        check_eq("halt2_mode", 32'(bus.mode), 32'h3);
        press(4'd2, 8'h22, nw);
        check_eq("halt_press_writes", 32'(nw), 32'h0);
        check_eq("halt_press_mode", 32'(bus.mode), 32'h0);
        check_eq("halt_press_count", 32'(bus.write_count), 32'h10);

        // start_rise and load_pulse in the same LOAD cycle: RUN wins, no write.
        bus.start = 1'b0;
        tick();
        bus.load_btn = 1'b1;
        repeat (6) tick();
        bus.start = 1'b1;
        tick();
        check_eq("tie_mode", 32'(bus.mode), 32'h2);
        check_eq("tie_clr", 32'(bus.cpu_clr), 32'h1);
        check_eq("tie_we", 32'(bus.ram_we), 32'h0);
        tick();
        check_eq("tie_stay_run", 32'(bus.mode), 32'h2);
        check_eq("tie_count", 32'(bus.write_count), 32'h10);

        // Reset in the middle of a WRITE drops it.
        do_reset();
        bus.sw_addr  = 4'd2;
        bus.sw_data  = 8'h22;
        bus.load_btn = 1'b1;
        repeat (7) tick();
        check_eq("pre_reset_we", 32'(bus.ram_we), 32'h1);
        reset = 1'b1;
        tick();
        check_reset_outputs("reset_in_write");
        reset = 1'b0;
        bus.load_btn = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
